// File: rtl/slug_ctrl.sv
// Game controller for the slug: start/play/hurt/game-over sequencing, button
// conditioning and motion requests to the slug position block.
// Latency: button pin to UP/DW is 3 clk (2-flop sync + output register). The
// start edge loads INIT one clk after the synchronized rising edge of btnC.
// Backpressure: none; the position block consumes UP/DW/leftEN/INIT as levels/pulses.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   btnU, btnD, btnC        raw buttons (asynchronous to clk)
//   Frame                   one-clk pulse per video frame
//   SlugV[14:0]             current slug vertical position (feedback)
//   Hit                     one-clk collision pulse
//   UP, DW                  registered move requests (PLAY only)
//   leftEN                  drift-left request while hurt
//   INIT                    one-clk position load pulse on game start
//   Playing                 high in PLAY and HURT
//   Flash                   sprite blink enable while hurt
//   Lives[1:0]              remaining lives
//
// Build option: define SLUG_CTRL_DEBOUNCE_EN to add a frame-sampled debounce
// (3 agreeing Frame samples) behind each synchronizer.

module slug_ctrl #(
    parameter logic [14:0] V_MIN       = 15'd16,
    parameter logic [14:0] V_MAX       = 15'd400,
    parameter logic [7:0]  HURT_FRAMES = 8'd60,
    parameter logic [1:0]  LIVES_INIT  = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnC,
    input  logic        Frame,
    input  logic [14:0] SlugV,
    input  logic        Hit,
    output logic        UP,
    output logic        DW,
    output logic        leftEN,
    output logic        INIT,
    output logic        Playing,
    output logic        Flash,
    output logic [1:0]  Lives
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HURT = 2'd2,
        S_OVER = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers, one per button. Bit order {C, D, U}.
    // ------------------------------------------------------------------
    logic [2:0] btn_meta_q;
    logic [2:0] btn_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 3'b000;
            btn_s_q    <= 3'b000;
        end else begin
            btn_meta_q <= {btnC, btnD, btnU};
            btn_s_q    <= btn_meta_q;
        end
    end

    // Conditioned button levels used by the rest of the controller.
    logic [2:0] btn_v;

`ifdef SLUG_CTRL_DEBOUNCE_EN
    // A button's debounced level only follows the synchronized level after
    // three consecutive Frame samples disagree with the current debounced
    // value; any agreeing sample restarts the count.
    logic [2:0]      db_q;
    logic [2:0]      db_d;
    logic [2:0][1:0] agree_q;
    logic [2:0][1:0] agree_d;

    always_comb begin
        db_d    = db_q;
        agree_d = agree_q;
        if (Frame) begin
            for (int i = 0; i < 3; i++) begin
                if (btn_s_q[i] == db_q[i]) begin
                    agree_d[i] = 2'd0;
                end else if (agree_q[i] == 2'd2) begin
                    db_d[i]    = btn_s_q[i];
                    agree_d[i] = 2'd0;
                end else begin
                    agree_d[i] = agree_q[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q    <= 3'b000;
            agree_q <= '0;
        end else begin
            db_q    <= db_d;
            agree_q <= agree_d;
        end
    end

    assign btn_v = db_q;
`else
    assign btn_v = btn_s_q;
`endif

    logic btn_u_v;
    logic btn_d_v;
    logic btn_c_v;

    assign btn_u_v = btn_v[0];
    assign btn_d_v = btn_v[1];
    assign btn_c_v = btn_v[2];

    // Start is the rising edge of the conditioned btnC level.
    logic c_prev_q;
    logic start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_prev_q <= 1'b0;
        end else begin
            c_prev_q <= btn_c_v;
        end
    end

    assign start = btn_c_v & ~c_prev_q;

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       init_q,  init_d;
    logic       up_q,    up_d;
    logic       dw_q,    dw_d;
    logic       v_above_min;
    logic       v_below_max;

    assign v_above_min = (SlugV > V_MIN);
    assign v_below_max = (SlugV < V_MAX);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        init_d  = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_PLAY;
                    init_d  = 1'b1;
                    lives_d = LIVES_INIT;
                end
            end
            S_PLAY: begin
                // The position block is being reloaded during INIT, so a
                // collision reported in that cycle is stale.
                if (Hit && !init_q) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = S_HURT;
                        cnt_d   = 8'd0;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end
                end
            end
            S_HURT: begin
                if (Frame) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == HURT_FRAMES) begin
                        state_d = S_PLAY;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Motion is qualified with the next state so UP/DW drop in the same
        // edge that leaves PLAY, and never show up in HURT/OVER.
        up_d = (state_d == S_PLAY) & btn_u_v & ~btn_d_v & v_above_min;
        dw_d = (state_d == S_PLAY) & btn_d_v & ~btn_u_v & v_below_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lives_q <= LIVES_INIT;
            cnt_q   <= 8'd0;
            init_q  <= 1'b0;
            up_q    <= 1'b0;
            dw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            up_q    <= up_d;
            dw_q    <= dw_d;
        end
    end

    // State-decoded outputs follow the async reset of state_q directly.
    assign UP      = up_q;
    assign DW      = dw_q;
    assign INIT    = init_q;
    assign leftEN  = (state_q == S_HURT);
    assign Playing = (state_q == S_PLAY) | (state_q == S_HURT);
    assign Flash   = (state_q == S_HURT) & cnt_q[3];
    assign Lives   = lives_q;

endmodule

// File: tb/tb_slug_ctrl.sv
module tb_slug_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnU  = 1'b0;
    logic        btnD  = 1'b0;
    logic        btnC  = 1'b0;
    logic        Frame = 1'b0;
    logic        Hit   = 1'b0;
    logic [14:0] SlugV = 15'd200;
    logic        UP, DW, leftEN, INIT, Playing, Flash;
    logic [1:0]  Lives;

    int checks   = 0;
    int failures = 0;

    slug_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btnU    (btnU),
        .btnD    (btnD),
        .btnC    (btnC),
        .Frame   (Frame),
        .SlugV   (SlugV),
        .Hit     (Hit),
        .UP      (UP),
        .DW      (DW),
        .leftEN  (leftEN),
        .INIT    (INIT),
        .Playing (Playing),
        .Flash   (Flash),
        .Lives   (Lives)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: game mode, lives and hurt frame count, plus the raw
    // pin history that the synchronizer delay implies.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_PLAY = 1, M_HURT = 2, M_OVER = 3;
    localparam int HURT_LEN = 60;

    int m_mode  = M_IDLE;
    int m_lives = 3;
    int m_fc    = 0;
    bit m_init  = 0;
    bit m_up    = 0;
    bit m_dw    = 0;
    bit hu[2]   = '{0, 0};   // [0] pin one edge ago, [1] two edges ago
    bit hd[2]   = '{0, 0};
    bit hc[3]   = '{0, 0, 0};
    bit m_start, m_old_init;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_lives = 3; m_fc = 0;
            m_init = 0; m_up = 0; m_dw = 0;
            hu = '{0, 0}; hd = '{0, 0}; hc = '{0, 0, 0};
        end else begin
            m_start    = hc[1] && !hc[2];
            m_old_init = m_init;
            m_init     = 0;
            if (m_mode == M_IDLE || m_mode == M_OVER) begin
                if (m_start) begin
                    m_mode = M_PLAY; m_init = 1; m_lives = 3;
                end
            end else if (m_mode == M_PLAY) begin
                if (Hit && !m_old_init) begin
                    if (m_lives > 1) begin
                        m_lives = m_lives - 1; m_mode = M_HURT; m_fc = 0;
                    end else begin
                        m_lives = 0; m_mode = M_OVER;
                    end
                end
            end else begin
                if (Frame) begin
                    m_fc = m_fc + 1;
                    if (m_fc == HURT_LEN) m_mode = M_PLAY;
                end
            end
            m_up = (m_mode == M_PLAY) && hu[1] && !hd[1] && (SlugV > 15'd16);
            m_dw = (m_mode == M_PLAY) && hd[1] && !hu[1] && (SlugV < 15'd400);
            hu[1] = hu[0]; hu[0] = btnU;
            hd[1] = hd[0]; hd[0] = btnD;
            hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = btnC;
        end
    end

    function automatic logic [7:0] exp_vec();
        logic f;
        logic [1:0] l;
        f = (m_mode == M_HURT) && (((m_fc / 8) % 2) == 1);
        l = 2'(m_lives);
        return {m_up, m_dw, (m_mode == M_HURT), m_init, f,
                (m_mode == M_PLAY || m_mode == M_HURT), l};
    endfunction

    logic [7:0] got_vec;
    assign got_vec = {UP, DW, leftEN, INIT, Flash, Playing, Lives};

    function automatic logic [14:0] pick_v();
        case ($urandom_range(0, 6))
            0: return 15'd15;
            1: return 15'd16;
            2: return 15'd17;
            3: return 15'd399;
            4: return 15'd400;
            5: return 15'd401;
            default: return 15'($urandom_range(0, 32767));
        endcase
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (got_vec !== 8'b0000_0011) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got_vec, 8'b0000_0011);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        int init_cnt = 0;
        btnC = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) btnC = 1'b0;
            if (INIT) init_cnt++;
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL start_cycle%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        checks++;
        if (init_cnt != 1 || Playing !== 1'b1 || Lives !== 2'd3) begin
            failures++;
            $display("FAIL start_init init_cnt=%0d playing=%b lives=%0d exp 1/1/3",
                     init_cnt, Playing, Lives);
        end
    endtask

    task automatic test_motion();
        // Floor: UP must stay low while held at V_MIN.
        SlugV = 15'd16; btnU = 1'b1; btnD = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (UP !== 1'b0 || got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL up_at_vmin got=%b exp=%b", got_vec, exp_vec());
            end
        end
        btnU = 1'b0;
        repeat (4) @(negedge clk);
        // Mid-screen: UP appears exactly 3 clk after the pin.
        SlugV = 15'd200; btnU = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (UP !== (i >= 3)) begin
                failures++;
                $display("FAIL up_latency clk=%0d got=%b exp=%b", i, UP, (i >= 3));
            end
        end
        btnD = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (UP !== 1'b0 || DW !== 1'b0) begin
            failures++;
            $display("FAIL both_held up=%b dw=%b exp 0/0", UP, DW);
        end
        for (int i = 0; i < 60; i++) begin
            btnU  = 1'($urandom_range(0, 1));
            btnD  = 1'($urandom_range(0, 1));
            SlugV = pick_v();
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL motion_rand%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        btnU = 1'b0; btnD = 1'b0; SlugV = 15'd200;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hurt();
        int frames = 0;
        int rises  = 0;
        logic pf = 1'b0;
        Hit = 1'b1;
        @(negedge clk);
        Hit = 1'b0;
        checks++;
        if (Lives !== 2'd2 || leftEN !== 1'b1 || Playing !== 1'b1 || Flash !== 1'b0) begin
            failures++;
            $display("FAIL hurt_entry lives=%0d left=%b play=%b flash=%b exp 2/1/1/0",
                     Lives, leftEN, Playing, Flash);
        end
        for (int i = 0; i < 140 && frames < HURT_LEN; i++) begin
            Frame = (i % 2 == 0);
            if (Frame) frames++;
            Hit   = (frames < 56) && ($urandom_range(0, 3) == 0);
            btnU  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (Flash && !pf) rises++;
            pf = Flash;
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL hurt_cycle%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        Frame = 1'b0; Hit = 1'b0; btnU = 1'b0;
        @(negedge clk);
        checks++;
        if (rises != 4 || Lives !== 2'd2 || leftEN !== 1'b0 || Playing !== 1'b1
            || Flash !== 1'b0) begin
            failures++;
            $display("FAIL hurt_exit rises=%0d lives=%0d left=%b play=%b flash=%b exp 4/2/0/1/0",
                     rises, Lives, leftEN, Playing, Flash);
        end
    endtask

    task automatic test_over();
        Hit = 1'b1;
        @(negedge clk);
        Hit = 1'b0;
        for (int i = 0; i < 62; i++) begin
            Frame = 1'b1;
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL over_hurt%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        Frame = 1'b0;
        btnU = 1'b1;
        repeat (3) @(negedge clk);
        Hit = 1'b1;
        @(negedge clk);
        Hit = 1'b0;
        checks++;
        if (got_vec !== 8'b0000_0000) begin
            failures++;
            $display("FAIL over_state got=%b exp=%b", got_vec, 8'b0000_0000);
        end
        Hit = 1'b1;
        @(negedge clk);
        Hit = 1'b0; btnU = 1'b0;
        checks++;
        if (Lives !== 2'd0 || Playing !== 1'b0) begin
            failures++;
            $display("FAIL over_hit_ignored lives=%0d play=%b exp 0/0", Lives, Playing);
        end
        // Restart, with a Hit landing in the INIT cycle.
        btnC = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) btnC = 1'b0;
            Hit = INIT;
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL restart%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        Hit = 1'b0;
        checks++;
        if (Lives !== 2'd3 || Playing !== 1'b1 || leftEN !== 1'b0) begin
            failures++;
            $display("FAIL init_hit_ignored lives=%0d play=%b left=%b exp 3/1/0",
                     Lives, Playing, leftEN);
        end
    endtask

    task automatic test_reset_mid();
        Hit = 1'b1;
        @(negedge clk);
        Hit = 1'b0;
        repeat (20) begin
            Frame = 1'b1;
            @(negedge clk);
        end
        Frame = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got_vec !== 8'b0000_0011) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", got_vec, 8'b0000_0011);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (INIT !== 1'b0 || got_vec !== 8'b0000_0011) begin
                failures++;
                $display("FAIL post_reset_idle%0d got=%b exp=%b", i, got_vec, 8'b0000_0011);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            btnU  = 1'($urandom_range(0, 1));
            btnD  = 1'($urandom_range(0, 1));
            btnC  = ($urandom_range(0, 15) == 0);
            Frame = ($urandom_range(0, 2) == 0);
            Hit   = ($urandom_range(0, 19) == 0);
            SlugV = pick_v();
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random%0d got=%b exp=%b", i, got_vec, exp_vec());
            end
        end
        btnU = 0; btnD = 0; btnC = 0; Frame = 0; Hit = 0;
    endtask

`ifdef SLUG_CTRL_DEBOUNCE_EN
    task automatic pulse_frames(input int n, inout bit saw_up);
        for (int k = 0; k < n; k++) begin
            Frame = 1'b1;
            @(negedge clk);
            saw_up |= UP;
            Frame = 1'b0;
            repeat (2) begin
                @(negedge clk);
                saw_up |= UP;
            end
        end
    endtask

    task automatic test_debounce();
        bit saw = 0;
        SlugV = 15'd200;
        btnC = 1'b1;
        repeat (3) @(negedge clk);
        pulse_frames(4, saw);
        btnC = 1'b0;
        repeat (3) @(negedge clk);
        pulse_frames(4, saw);
        checks++;
        if (Playing !== 1'b1 || Lives !== 2'd3) begin
            failures++;
            $display("FAIL db_start play=%b lives=%0d exp 1/3", Playing, Lives);
        end
        saw = 0;
        btnU = 1'b1;
        repeat (3) @(negedge clk);
        pulse_frames(2, saw);
        btnU = 1'b0;
        repeat (3) @(negedge clk);
        pulse_frames(4, saw);
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL db_glitch up_seen=%b exp 0", saw);
        end
        saw = 0;
        btnU = 1'b1;
        repeat (3) @(negedge clk);
        pulse_frames(3, saw);
        checks++;
        if (saw !== 1'b1 || UP !== 1'b1) begin
            failures++;
            $display("FAIL db_hold up_seen=%b up=%b exp 1/1", saw, UP);
        end
        btnU = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef SLUG_CTRL_DEBOUNCE_EN
        test_debounce();
`else
        test_start();
        test_motion();
        test_hurt();
        test_over();
        test_reset_mid();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slug_ctrl.md
SLUG_CTRL -- requirements
Module: slug_ctrl

Interface
REQ-001 Parameter V_MIN, default 15'd16, lowest legal SlugV; UP is blocked at or below it.
REQ-002 Parameter V_MAX, default 15'd400, highest legal SlugV; DW is blocked at or above it.
REQ-003 Parameter HURT_FRAMES, default 8'd60, length of the hurt phase in Frame pulses.
REQ-004 Parameter LIVES_INIT, default 2'd3, lives loaded on reset and on game start.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 btnU  in  1  raw up button, asynchronous to clk.
REQ-008 btnD  in  1  raw down button, asynchronous to clk.
REQ-009 btnC  in  1  raw start button, asynchronous to clk.
REQ-010 Frame  in  1  one-clk pulse per video frame.
REQ-011 SlugV  in  15  current slug vertical position, fed back from the slug position block.
REQ-012 Hit  in  1  one-clk collision pulse from the collision logic.
REQ-013 UP  out  1  move-up request to the slug position block.
REQ-014 DW  out  1  move-down request to the slug position block.
REQ-015 leftEN  out  1  horizontal drift-left request to the slug position block.
REQ-016 INIT  out  1  one-clk position load pulse to the slug position block.
REQ-017 Playing  out  1  high in PLAY and HURT.
REQ-018 Flash  out  1  sprite blink enable during HURT.
REQ-019 Lives  out  2  remaining lives.

Function
REQ-020 btnU, btnD and btnC SHALL each pass through a 2-flop synchronizer; btnC start SHALL be detected on the synchronized rising edge.
REQ-021 The FSM SHALL have exactly four states: IDLE, PLAY, HURT, OVER.
REQ-022 IDLE or OVER, on a btnC rising edge: next cycle INIT=1 for exactly one clk, Lives=LIVES_INIT, state goes to PLAY.
REQ-023 In PLAY, UP SHALL be registered as btnU_s & ~btnD_s & (SlugV > V_MIN).
REQ-024 In PLAY, DW SHALL be registered as btnD_s & ~btnU_s & (SlugV < V_MAX).
REQ-025 With both buttons held, UP=DW=0; latency from a stable button pin to UP/DW is 3 clk.
REQ-026 In PLAY, Hit with Lives>1 SHALL decrement Lives and enter HURT; Hit with Lives==1 SHALL set Lives=0 and enter OVER.
REQ-027 In HURT, UP=DW=0 and leftEN=1; Hit SHALL be ignored.
REQ-028 In HURT, an 8-bit frame counter SHALL clear on entry and increment on each Frame.
REQ-029 In HURT, Flash SHALL equal counter bit 3; on the Frame that brings the counter to HURT_FRAMES, the FSM SHALL return to PLAY and clear Flash.
REQ-030 In IDLE and OVER, UP, DW, leftEN, Flash and Playing SHALL be 0; Hit SHALL be ignored.
REQ-031 Hit and Frame in the same cycle: Hit takes priority, and the counter starts from 0.
REQ-032 Hit in the INIT cycle SHALL be ignored.
REQ-033 Lives SHALL never underflow below 0.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, Lives=LIVES_INIT, counter 0, all synchronizer and edge flops 0, UP=DW=leftEN=INIT=Flash=Playing=0.
REQ-035 A reset mid-game SHALL abandon the game with no INIT pulse; a new btnC edge is required to start.

Configuration
REQ-036 SLUG_CTRL_DEBOUNCE_EN defined: each synchronized button SHALL update its debounced value only after 3 consecutive Frame samples agree; UP, DW and the start edge SHALL use the debounced values.
REQ-037 SLUG_CTRL_DEBOUNCE_EN undefined: the synchronized values SHALL be used directly, with no debounce logic.

Verification
REQ-038 Reset, then btnC pulse -> INIT high exactly 1 clk, Playing=1, Lives=3.
REQ-039 PLAY, SlugV=16, btnU held -> UP stays 0; SlugV=200, btnU held -> UP=1 after 3 clk; btnU+btnD held -> UP=DW=0.
REQ-040 PLAY, Lives=3, Hit -> Lives=2, leftEN=1, Flash toggles every 8 Frames, PLAY resumes after 60 Frames; a Hit during HURT leaves Lives=2.
REQ-041 Lives=1, Hit -> Lives=0, state OVER, all motion outputs 0; btnC -> INIT pulse, Lives=3.
REQ-042 rst_n low mid-HURT -> outputs 0 asynchronously, Lives=3, IDLE, no INIT.
REQ-043 DEBOUNCE_EN: btnU glitch lasting under 3 Frames -> UP never asserts; btnU held 3 Frames -> UP asserts.
